systolic_operand_feeder: RTL

SYSTOLIC_OPERAND_FEEDER -- requirements
Module: systolic_operand_feeder

---
 rtl/systolic_operand_feeder.sv | 112 +++++++++++
 1 files changed

// File: rtl/systolic_operand_feeder.sv
// Feeds skewed rows of A and columns of B into an N x N systolic array, then
// waits for the array to report completion.
module systolic_operand_feeder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N*N)-1:0] wr_addr,
  input  logic [W-1:0]           wr_data,
  input  logic                   go,
  input  logic                   array_done,
  output logic [N*W-1:0]         row_operand,
  output logic [N*W-1:0]         col_operand,
  output logic                   pe_start,
  output logic                   pe_clear,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KW = $clog2(2 * N);
  localparam logic [KW-1:0] KLast = KW'(2 * N - 2);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_mem [N*N];
  logic [W-1:0]   b_mem [N*N];
  logic [N*W-1:0] row_d, col_d;
  logic           wr_ok;

  assign wr_ok = wr_en && (state_q == StIdle) && (32'(wr_addr) < N * N);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StClear;
          k_d     = '0;
        end
      end
      StClear: begin
        state_d = StFeed;
        k_d     = '0;
      end
      StFeed: begin
        if (k_q == KLast) state_d = StDrain;
        else k_d = k_q + 1'b1;
      end
      StDrain: if (array_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so the registered lanes line up with the beat.
  always_comb begin
    int d;
    row_d = '0;
    col_d = '0;
    d     = 0;
    if (state_d == StFeed) begin
      for (int i = 0; i < int'(N); i++) begin
        d = int'(k_d) - i;
        if (d >= 0 && d < int'(N)) begin
          row_d[i*W +: W] = a_mem[i*int'(N) + d];
          col_d[i*W +: W] = b_mem[d*int'(N) + i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      row_operand <= '0;
      col_operand <= '0;
      pe_start    <= 1'b0;
      pe_clear    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      row_operand <= row_d;
      col_operand <= col_d;
      pe_start    <= (state_d == StFeed);
      pe_clear    <= (state_d == StClear);
      busy        <= (state_d != StIdle);
      done        <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N * N); i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) b_mem[wr_addr] <= wr_data;
      else a_mem[wr_addr] <= wr_data;
    end
  end

endmodule
